// File: rtl/mbf_chan_scheduler.sv
// Round-robin sample issue and config sequencing in front of the shared
// multichannel decimator in the MHBF DDC chain.
module mbf_chan_scheduler #(
    parameter int DATA_WIDTH  = 24,
    parameter int MAX_CH      = 2,
    parameter int CFG_WIDTH   = 16,
    parameter int VALID_HIGH  = 2,
    parameter int VALID_LOW   = 2,
    parameter int CFG_TIMEOUT = 64
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [MAX_CH-1:0]            Ch_Req,
    input  logic [MAX_CH*DATA_WIDTH-1:0] Ch_Data,
    output logic [MAX_CH-1:0]            Ch_Ack,
    input  logic                         Cfg_Start,
    input  logic [CFG_WIDTH-1:0]         Cfg_Dcef,
    output logic                         Cfg_Busy,
    output logic                         Cfg_Err,
    output logic                         Dec_isConfig,
    output logic [CFG_WIDTH-1:0]         Dec_Config_Data,
    input  logic                         Dec_isConfigDone,
    output logic [DATA_WIDTH-1:0]        Dec_Data,
    output logic                         Dec_Data_Valid,
    output logic [3:0]                   Dec_ChIdx
);

    localparam int SLOT_MAX = (VALID_HIGH > VALID_LOW) ? VALID_HIGH : VALID_LOW;
    localparam int CNT_W    = $clog2(SLOT_MAX + 1);
    localparam int TMO_W    = $clog2(CFG_TIMEOUT + 1);

    localparam logic [CNT_W-1:0] VH_LAST = CNT_W'(VALID_HIGH - 1);
    localparam logic [CNT_W-1:0] VL_LAST = CNT_W'(VALID_LOW - 1);
    localparam logic [TMO_W-1:0] TO_LAST = TMO_W'(CFG_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_GAP,
        S_CFG_REQ,
        S_CFG_WAIT
    } state_t;

    state_t                  state_q;
    logic [3:0]              rr_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [TMO_W-1:0]        tmo_q;
    logic                    pend_q;
    logic                    busy_q;
    logic                    err_q;
    logic                    isc_q;
    logic [CFG_WIDTH-1:0]    cfg_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [3:0]              idx_q;
    logic                    vld_q;

    logic [2*MAX_CH-1:0]     req_dbl;
    logic [MAX_CH-1:0]       req_rot;
    logic [MAX_CH-1:0]       ack_oh;
    logic                    gnt_vld;
    logic                    grant;
    int                      gnt_off;
    int                      gnt_sum;
    logic [3:0]              gnt_idx;
    logic [3:0]              rr_d;
    logic [DATA_WIDTH-1:0]   gnt_data;

    // Rotate requests so the RR pointer lands on bit 0, then pick the lowest set bit.
    always_comb begin
        req_dbl  = {Ch_Req, Ch_Req};
        req_rot  = MAX_CH'(req_dbl >> rr_q);
        gnt_vld  = 1'b0;
        gnt_off  = 0;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                gnt_vld = 1'b1;
                gnt_off = i;
            end
        end
        gnt_sum = int'(rr_q) + gnt_off;
        if (gnt_sum >= MAX_CH) begin
            gnt_sum = gnt_sum - MAX_CH;
        end
        gnt_idx  = 4'(gnt_sum);
        rr_d     = (gnt_sum == MAX_CH - 1) ? 4'd0 : 4'(gnt_sum + 1);
        gnt_data = '0;
        ack_oh   = '0;
        for (int i = 0; i < MAX_CH; i++) begin
            if (i == gnt_sum) begin
                gnt_data  = Ch_Data[i*DATA_WIDTH +: DATA_WIDTH];
                ack_oh[i] = 1'b1;
            end
        end
    end

    assign grant = !RST && (state_q == S_IDLE) && !pend_q && gnt_vld;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            pend_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            isc_q   <= 1'b0;
            cfg_q   <= '0;
            data_q  <= '0;
            idx_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            if (Cfg_Start && !busy_q) begin
                if (Cfg_Dcef == '0) begin
                    err_q <= 1'b1;
                end else begin
                    cfg_q  <= Cfg_Dcef;
                    pend_q <= 1'b1;
                    busy_q <= 1'b1;
                    err_q  <= 1'b0;
                end
            end
            unique case (state_q)
                S_IDLE: begin
                    if (pend_q) begin
                        isc_q   <= 1'b1;
                        state_q <= S_CFG_REQ;
                    end else if (gnt_vld) begin
                        data_q  <= gnt_data;
                        idx_q   <= gnt_idx;
                        rr_q    <= rr_d;
                        vld_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (cnt_q == VH_LAST) begin
                        vld_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= S_GAP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt_q == VL_LAST) begin
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_CFG_REQ: begin
                    isc_q   <= 1'b0;
                    pend_q  <= 1'b0;
                    tmo_q   <= '0;
                    state_q <= S_CFG_WAIT;
                end
                S_CFG_WAIT: begin
                    if (Dec_isConfigDone) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (tmo_q == TO_LAST) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign Ch_Ack          = grant ? ack_oh : '0;
    assign Cfg_Busy        = busy_q;
    assign Cfg_Err         = err_q;
    assign Dec_isConfig    = isc_q;
    assign Dec_Config_Data = cfg_q;
    assign Dec_Data        = data_q;
    assign Dec_Data_Valid  = vld_q;
    assign Dec_ChIdx       = idx_q;

endmodule

// File: tb/tb_mbf_chan_scheduler.sv
// Bench for mbf_chan_scheduler: randomized requesters checked against a
// slot-timing / round-robin reference model, plus directed config scenarios.
module tb_mbf_chan_scheduler;

    localparam int DW   = 24;
    localparam int N    = 2;
    localparam int CW   = 16;
    localparam int VH   = 2;
    localparam int VL   = 2;
    localparam int TO   = 64;
    localparam int SLOT = 1 + VH + VL;

    logic            CLK = 1'b0;
    logic            RST;
    logic [N-1:0]    Ch_Req;
    logic [N*DW-1:0] Ch_Data;
    logic [N-1:0]    Ch_Ack;
    logic            Cfg_Start;
    logic [CW-1:0]   Cfg_Dcef;
    logic            Cfg_Busy;
    logic            Cfg_Err;
    logic            Dec_isConfig;
    logic [CW-1:0]   Dec_Config_Data;
    logic            Dec_isConfigDone;
    logic [DW-1:0]   Dec_Data;
    logic            Dec_Data_Valid;
    logic [3:0]      Dec_ChIdx;

    int tests = 0;
    int fails = 0;

    logic [N-1:0]  req_m;
    logic [DW-1:0] data_m [N];
    int            since;
    int            rr_m;
    logic [DW-1:0] exp_data;
    int            exp_idx;

    mbf_chan_scheduler #(
        .DATA_WIDTH(DW), .MAX_CH(N), .CFG_WIDTH(CW),
        .VALID_HIGH(VH), .VALID_LOW(VL), .CFG_TIMEOUT(TO)
    ) dut (
        .CLK(CLK), .RST(RST),
        .Ch_Req(Ch_Req), .Ch_Data(Ch_Data), .Ch_Ack(Ch_Ack),
        .Cfg_Start(Cfg_Start), .Cfg_Dcef(Cfg_Dcef),
        .Cfg_Busy(Cfg_Busy), .Cfg_Err(Cfg_Err),
        .Dec_isConfig(Dec_isConfig), .Dec_Config_Data(Dec_Config_Data),
        .Dec_isConfigDone(Dec_isConfigDone),
        .Dec_Data(Dec_Data), .Dec_Data_Valid(Dec_Data_Valid),
        .Dec_ChIdx(Dec_ChIdx)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic drive();
        Ch_Req = req_m;
        for (int i = 0; i < N; i++) Ch_Data[i*DW +: DW] = data_m[i];
    endtask

    task automatic apply_reset();
        RST = 1'b1;
        req_m = '0;
        Cfg_Start = 1'b0;
        Cfg_Dcef = '0;
        Dec_isConfigDone = 1'b0;
        drive();
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        since = 100;
        rr_m = 0;
        exp_data = '0;
        exp_idx = 0;
    endtask

    // mode 0: requests held; 1: drop on ack; 2: random raise/withdraw
    task automatic run_model(input int cycles, input int mode, output int nack);
        int g;
        int c;
        logic [N-1:0] exp_ack;
        nack = 0;
        drive();
        for (int k = 0; k < cycles; k++) begin
            @(negedge CLK);
            g = -1;
            exp_ack = '0;
            if (since >= SLOT) begin
                for (int i = 0; i < N; i++) begin
                    c = (rr_m + i) % N;
                    if (g < 0 && req_m[c]) g = c;
                end
            end
            if (g >= 0) exp_ack[g] = 1'b1;
            if (|Ch_Ack) nack++;
            tests++;
            if (Ch_Ack !== exp_ack) begin
                fails++;
                $display("FAIL ack @%0t: got %b expected %b", $time, Ch_Ack, exp_ack);
            end
            tests++;
            if (Dec_Data_Valid !== (since >= 1 && since <= VH)) begin
                fails++;
                $display("FAIL valid @%0t: got %b since=%0d", $time, Dec_Data_Valid, since);
            end
            tests++;
            if (Dec_Data !== exp_data || Dec_ChIdx !== 4'(exp_idx)) begin
                fails++;
                $display("FAIL data/idx @%0t: got %h/%0d expected %h/%0d",
                         $time, Dec_Data, Dec_ChIdx, exp_data, exp_idx);
            end
            if (g >= 0) begin
                since = 1;
                rr_m = (g + 1) % N;
                exp_data = data_m[g];
                exp_idx = g;
            end else if (since < 100) begin
                since++;
            end
            @(posedge CLK);
            #1;
            for (int i = 0; i < N; i++) begin
                if (i == g) begin
                    if (mode != 0) req_m[i] = 1'b0;
                end else if (mode == 2) begin
                    if (req_m[i]) begin
                        if ($urandom_range(7) == 0) req_m[i] = 1'b0;
                    end else if ($urandom_range(1) == 0) begin
                        req_m[i] = 1'b1;
                        data_m[i] = DW'($urandom);
                    end
                end
            end
            drive();
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        req_m = 2'b11;
        data_m[0] = 24'hABCDEF;
        data_m[1] = 24'h123456;
        Cfg_Start = 1'b0;
        Cfg_Dcef = '0;
        Dec_isConfigDone = 1'b0;
        drive();
        @(negedge CLK);
        tests++;
        if ({Ch_Ack, Dec_Data_Valid, Dec_isConfig, Cfg_Busy, Cfg_Err} !== '0) begin
            fails++;
            $display("FAIL reset_ctrl: ack=%b vld=%b isc=%b busy=%b err=%b",
                     Ch_Ack, Dec_Data_Valid, Dec_isConfig, Cfg_Busy, Cfg_Err);
        end
        tests++;
        if ({Dec_Data, Dec_ChIdx, Dec_Config_Data} !== '0) begin
            fails++;
            $display("FAIL reset_data: data=%h idx=%0d cfg=%h",
                     Dec_Data, Dec_ChIdx, Dec_Config_Data);
        end
    endtask

    task automatic test_round_robin();
        int n;
        apply_reset();
        req_m = 2'b11;
        data_m[0] = 24'h000011;
        data_m[1] = 24'h000022;
        run_model(30, 0, n);
        tests++;
        if (n != (30 + SLOT - 1) / SLOT) begin
            fails++;
            $display("FAIL rr_rate: got %0d acks expected %0d", n, (30 + SLOT - 1) / SLOT);
        end
    endtask

    task automatic test_single_ch1();
        int n;
        apply_reset();
        req_m = 2'b10;
        data_m[1] = 24'h5A5A5A;
        run_model(SLOT, 1, n);
        tests++;
        if (n != 1) begin
            fails++;
            $display("FAIL single_ch1: got %0d acks expected 1", n);
        end
        req_m = 2'b11;
        data_m[0] = 24'hC0FFEE;
        run_model(2 * SLOT, 0, n);
        tests++;
        if (n != 2) begin
            fails++;
            $display("FAIL wrap: got %0d acks expected 2", n);
        end
    endtask

    task automatic test_random();
        int n;
        apply_reset();
        for (int i = 0; i < N; i++) data_m[i] = DW'($urandom);
        run_model(600, 2, n);
        tests++;
        if (n < 20) begin
            fails++;
            $display("FAIL random_traffic: got %0d acks expected >= 20", n);
        end
    endtask

    task automatic test_cfg_ok();
        int cfg_cyc, ncfg, ack2, busy_low;
        logic busy2;
        logic [CW-1:0] cdata;
        logic [N-1:0] ack2v;
        apply_reset();
        req_m = 2'b11;
        data_m[0] = 24'h000011;
        data_m[1] = 24'h000022;
        drive();
        cfg_cyc = -1; ncfg = 0; ack2 = -1; busy_low = -1;
        busy2 = 1'b0; cdata = '0; ack2v = '0;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            if (Dec_isConfig) begin
                ncfg++;
                if (cfg_cyc < 0) cfg_cyc = k;
                cdata = Dec_Config_Data;
            end
            if (k == 2) busy2 = Cfg_Busy;
            if (k > 0 && ack2 < 0 && |Ch_Ack) begin
                ack2 = k;
                ack2v = Ch_Ack;
            end
            if (cfg_cyc >= 0 && busy_low < 0 && !Cfg_Busy) busy_low = k;
            @(posedge CLK);
            #1;
            Cfg_Start = (k == 0);
            Cfg_Dcef = CW'(4);
            Dec_isConfigDone = (cfg_cyc >= 0 && k + 1 == cfg_cyc + 2);
        end
        tests++;
        if (cfg_cyc != SLOT + 1) begin
            fails++;
            $display("FAIL cfg_after_slot: isConfig at %0d expected %0d", cfg_cyc, SLOT + 1);
        end
        tests++;
        if (ncfg != 1 || cdata !== CW'(4)) begin
            fails++;
            $display("FAIL cfg_strobe: %0d cycles data=%0d expected 1 cycle data=4", ncfg, cdata);
        end
        tests++;
        if (busy2 !== 1'b1) begin
            fails++;
            $display("FAIL cfg_busy_rise: got %b expected 1", busy2);
        end
        tests++;
        if (busy_low != cfg_cyc + 3) begin
            fails++;
            $display("FAIL cfg_busy_drop: at %0d expected %0d", busy_low, cfg_cyc + 3);
        end
        tests++;
        if (ack2 != cfg_cyc + 3 || ack2v !== 2'b10) begin
            fails++;
            $display("FAIL cfg_resume: ack %b at %0d expected 10 at %0d", ack2v, ack2, cfg_cyc + 3);
        end
        tests++;
        if (Cfg_Err !== 1'b0) begin
            fails++;
            $display("FAIL cfg_ok_err: got %b expected 0", Cfg_Err);
        end
    endtask

    task automatic test_cfg_timeout();
        int cfg_cyc, ack2, busy_low, err_cyc;
        logic [N-1:0] ack2v;
        apply_reset();
        req_m = 2'b11;
        drive();
        cfg_cyc = -1; ack2 = -1; busy_low = -1; err_cyc = -1; ack2v = '0;
        for (int k = 0; k < 90; k++) begin
            @(negedge CLK);
            if (Dec_isConfig && cfg_cyc < 0) cfg_cyc = k;
            if (k > 0 && ack2 < 0 && |Ch_Ack) begin
                ack2 = k;
                ack2v = Ch_Ack;
            end
            if (cfg_cyc >= 0 && busy_low < 0 && !Cfg_Busy) busy_low = k;
            if (err_cyc < 0 && Cfg_Err) err_cyc = k;
            @(posedge CLK);
            #1;
            Cfg_Start = (k == 0 || k == 19 || k == 21);
            Cfg_Dcef = (k == 19) ? CW'(9) : (k == 21) ? CW'(0) : CW'(3);
        end
        Cfg_Start = 1'b0;
        tests++;
        if (busy_low != cfg_cyc + 1 + TO) begin
            fails++;
            $display("FAIL tmo_busy: drop at %0d expected %0d", busy_low, cfg_cyc + 1 + TO);
        end
        tests++;
        if (err_cyc != cfg_cyc + 1 + TO) begin
            fails++;
            $display("FAIL tmo_err: set at %0d expected %0d", err_cyc, cfg_cyc + 1 + TO);
        end
        tests++;
        if (ack2 != cfg_cyc + 1 + TO || ack2v !== 2'b10) begin
            fails++;
            $display("FAIL tmo_resume: ack %b at %0d expected 10 at %0d",
                     ack2v, ack2, cfg_cyc + 1 + TO);
        end
        tests++;
        if (Dec_Config_Data !== CW'(3) || Cfg_Err !== 1'b1 || Cfg_Busy !== 1'b0) begin
            fails++;
            $display("FAIL tmo_hold: cfg=%0d err=%b busy=%b expected 3/1/0",
                     Dec_Config_Data, Cfg_Err, Cfg_Busy);
        end
    endtask

    task automatic test_cfg_zero();
        int ncfg_early, ncfg;
        logic err2, busy2, err11, busy11;
        logic [CW-1:0] cdata;
        apply_reset();
        drive();
        ncfg_early = 0; ncfg = 0; cdata = '0;
        err2 = 1'b0; busy2 = 1'b1; err11 = 1'b1; busy11 = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge CLK);
            if (Dec_isConfig) begin
                ncfg++;
                cdata = Dec_Config_Data;
                if (k < 10) ncfg_early++;
            end
            if (k == 2) begin err2 = Cfg_Err; busy2 = Cfg_Busy; end
            if (k == 11) begin err11 = Cfg_Err; busy11 = Cfg_Busy; end
            @(posedge CLK);
            #1;
            Cfg_Start = (k == 0 || k == 9);
            Cfg_Dcef = (k == 9) ? CW'(2) : CW'(0);
            Dec_isConfigDone = (k + 1 == 14);
        end
        tests++;
        if (err2 !== 1'b1 || busy2 !== 1'b0 || ncfg_early != 0) begin
            fails++;
            $display("FAIL zero_dcef: err=%b busy=%b isc=%0d expected 1/0/0",
                     err2, busy2, ncfg_early);
        end
        tests++;
        if (err11 !== 1'b0 || busy11 !== 1'b1) begin
            fails++;
            $display("FAIL err_clear: err=%b busy=%b expected 0/1", err11, busy11);
        end
        tests++;
        if (ncfg != 1 || cdata !== CW'(2) || Cfg_Busy !== 1'b0) begin
            fails++;
            $display("FAIL zero_then_2: isc=%0d data=%0d busy=%b expected 1/2/0",
                     ncfg, cdata, Cfg_Busy);
        end
    endtask

    task automatic test_rst_mid();
        int cfg_cyc;
        for (int pass = 0; pass < 2; pass++) begin
            apply_reset();
            req_m = 2'b11;
            data_m[0] = 24'h111111;
            data_m[1] = 24'h222222;
            drive();
            cfg_cyc = -1;
            if (pass == 0) begin
                for (int k = 0; k < 20; k++) begin
                    @(negedge CLK);
                    if (Dec_isConfig && cfg_cyc < 0) cfg_cyc = k;
                    @(posedge CLK);
                    #1;
                    Cfg_Start = (k == 0);
                    Cfg_Dcef = CW'(5);
                    if (cfg_cyc >= 0 && k == cfg_cyc + 2) break;
                end
                Cfg_Start = 1'b0;
                tests++;
                if (cfg_cyc < 0) begin
                    fails++;
                    $display("FAIL rst_cfg_setup: no isConfig within 20 cycles");
                end
            end else begin
                @(negedge CLK);
                @(posedge CLK);
                #1;
            end
            RST = 1'b1;
            @(negedge CLK);
            tests++;
            if ({Ch_Ack, Dec_Data_Valid, Dec_isConfig, Cfg_Busy, Cfg_Err,
                 Dec_Data, Dec_ChIdx, Dec_Config_Data} !== '0) begin
                fails++;
                $display("FAIL rst_mid%0d: ack=%b vld=%b isc=%b busy=%b data=%h idx=%0d cfg=%h",
                         pass, Ch_Ack, Dec_Data_Valid, Dec_isConfig, Cfg_Busy,
                         Dec_Data, Dec_ChIdx, Dec_Config_Data);
            end
            @(posedge CLK);
            #1;
            RST = 1'b0;
            @(negedge CLK);
            tests++;
            if (Ch_Ack !== 2'b01 || Dec_Data_Valid !== 1'b0 || Dec_isConfig !== 1'b0) begin
                fails++;
                $display("FAIL rst_release%0d: ack=%b vld=%b isc=%b expected 01/0/0",
                         pass, Ch_Ack, Dec_Data_Valid, Dec_isConfig);
            end
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_ch1();
        test_random();
        test_cfg_ok();
        test_cfg_timeout();
        test_cfg_zero();
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
